amci_sequencer: RTL
===================

AMCI_SEQUENCER -- requirements
Module: amci_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, command queue entries; power of two, >=2.
REQ-004 SHALL have port CLK, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports CMD_VALID input 1 / CMD_READY output 1: command handshake; transfer when both high on an edge.
REQ-007 SHALL have port CMD_OP, input, 1, 0=write, 1=read.
REQ-008 SHALL have ports CMD_ADDR input ADDR_WIDTH and CMD_DATA input DATA_WIDTH; CMD_DATA is ignored for reads.
REQ-009 SHALL have ports RSP_VALID output 1, RSP_READY input 1, RSP_DATA output DATA_WIDTH: read-result stream.
REQ-010 SHALL have port FIFO_COUNT, output, clog2(FIFO_DEPTH)+1, queued command count.
REQ-011 SHALL have port BUSY, output, 1, high when FSM not IDLE or FIFO_COUNT!=0.
REQ-012 SHALL have ports AMCI_WADDR out ADDR_WIDTH, AMCI_WDATA out DATA_WIDTH, AMCI_WRITE out 1, AMCI_WIDLE in 1: downstream write-request interface.
REQ-013 SHALL have ports AMCI_RADDR out ADDR_WIDTH, AMCI_READ out 1, AMCI_RDATA in DATA_WIDTH, AMCI_RIDLE in 1: downstream read-request interface.

Function
REQ-014 SHALL hold commands in a FIFO_DEPTH-entry FIFO of {op, addr, data}; CMD_READY = (FIFO_COUNT < FIFO_DEPTH), combinational from registered count.
REQ-015 SHALL, on push and pop in the same cycle, leave FIFO_COUNT unchanged and keep order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL run FSM states IDLE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R.
REQ-017 IDLE: if FIFO non-empty and head op=0 and AMCI_WIDLE=1 -> pop, register AMCI_WADDR/AMCI_WDATA from head, set AMCI_WRITE=1, go ISSUE_W.
REQ-018 IDLE: if FIFO non-empty, head op=1, AMCI_RIDLE=1 and RSP_VALID=0 -> pop, register AMCI_RADDR, set AMCI_READ=1, go ISSUE_R; otherwise remain IDLE, head not popped.
REQ-019 ISSUE_W/ISSUE_R: AMCI_WRITE/AMCI_READ SHALL be high for exactly this one cycle, cleared at its end; next state WAIT_W/WAIT_R unconditionally.
REQ-020 WAIT_W: remain until AMCI_WIDLE=1, then go IDLE.
REQ-021 WAIT_R: remain until AMCI_RIDLE=1; on that edge capture AMCI_RDATA into RSP_DATA, set RSP_VALID=1, go IDLE.
REQ-022 AMCI_WRITE and AMCI_READ SHALL be flop outputs with no combinational path from AMCI_WIDLE/AMCI_RIDLE (downstream idle flags depend on these strobes).
REQ-023 AMCI_WADDR/WDATA/RADDR SHALL hold stable from ISSUE through end of WAIT.
REQ-024 SHALL execute commands strictly in queue order, one outstanding at a time; writes produce no response.
REQ-025 RSP_VALID SHALL clear on edge with RSP_VALID&RSP_READY; RSP_DATA SHALL not change while RSP_VALID=1 and unacknowledged.
REQ-026 Minimum latency: command pushed edge N -> AMCI strobe high cycle N+2 (FIFO not bypassed).
REQ-027 A read head SHALL stall in IDLE while RSP_VALID=1 (one-entry result buffer); a write head SHALL not stall on RSP_VALID.

Reset
REQ-028 On RESET=1 at an edge: FIFO emptied (FIFO_COUNT=0, pointers 0), FSM=IDLE, AMCI_WRITE=0, AMCI_READ=0, RSP_VALID=0, BUSY=0; CMD_READY=1 the following cycle.
REQ-029 AMCI_WADDR/WDATA/RADDR/RSP_DATA SHALL reset to 0.
REQ-030 Reset mid-transaction SHALL discard the in-flight command and any result; downstream block is reset by the same RESET.

Verification
REQ-031 Single write: push op=0 addr=0x10 data=0xDEADBEEF, downstream idle -> one-cycle AMCI_WRITE two cycles later with AMCI_WADDR=0x10, AMCI_WDATA=0xDEADBEEF; no RSP_VALID.
REQ-032 Single read: push op=1 addr=0x20, model returns 0x12345678 after 5 cycles -> RSP_VALID=1, RSP_DATA=0x12345678, held until RSP_READY.
REQ-033 Full/ordering: RSP_READY=1, downstream stalled; push 9 mixed cmds -> CMD_READY=0 once FIFO_COUNT=8; all 9 issued in push order after release.
REQ-034 Backpressure: RSP_READY=0, two reads queued -> second AMCI_READ not asserted until first response accepted; queued write ahead of it still issues.
REQ-035 Reset in WAIT_R with 3 queued -> next cycle FIFO_COUNT=0, RSP_VALID=0, AMCI_READ=0, BUSY=0; no response appears.
REQ-036 Simultaneous push/pop at FIFO_COUNT=3 -> FIFO_COUNT stays 3.

Source files
------------

// File: rtl/amci_sequencer_if.sv
// Bundle of the command, response and downstream AMCI request signals of amci_sequencer.
// slave is the sequencer's own view; master is the view of whatever sits around it.
interface amci_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_OP;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_DATA;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_DATA;

  logic [ADDR_WIDTH-1:0] AMCI_WADDR;
  logic [DATA_WIDTH-1:0] AMCI_WDATA;
  logic                  AMCI_WRITE;
  logic                  AMCI_WIDLE;

  logic [ADDR_WIDTH-1:0] AMCI_RADDR;
  logic                  AMCI_READ;
  logic [DATA_WIDTH-1:0] AMCI_RDATA;
  logic                  AMCI_RIDLE;

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA,
    output CMD_READY,
    output RSP_VALID, RSP_DATA,
    input  RSP_READY,
    output AMCI_WADDR, AMCI_WDATA, AMCI_WRITE,
    input  AMCI_WIDLE,
    output AMCI_RADDR, AMCI_READ,
    input  AMCI_RDATA, AMCI_RIDLE
  );

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA,
    input  CMD_READY,
    input  RSP_VALID, RSP_DATA,
    output RSP_READY,
    input  AMCI_WADDR, AMCI_WDATA, AMCI_WRITE,
    output AMCI_WIDLE,
    input  AMCI_RADDR, AMCI_READ,
    output AMCI_RDATA, AMCI_RIDLE
  );
endinterface

// File: rtl/amci_sequencer.sv
// Queues write/read commands and replays them one at a time onto the AMCI
// request ports; read results go out through a one-entry response buffer.
//
// state     | meaning
// IDLE      | waiting for a queued command whose downstream port is idle
// ISSUE_W   | AMCI_WRITE strobe high for this single cycle
// WAIT_W    | waiting for AMCI_WIDLE to return
// ISSUE_R   | AMCI_READ strobe high for this single cycle
// WAIT_R    | waiting for AMCI_RIDLE, then capture AMCI_RDATA
module amci_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  amci_sequencer_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        BUSY
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_W = 3'd1;
  localparam logic [2:0] S_WAIT_W  = 3'd2;
  localparam logic [2:0] S_ISSUE_R = 3'd3;
  localparam logic [2:0] S_WAIT_R  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  mem_op_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  cmd_ready;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  head_op;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign cmd_ready  = (count_q < DEPTH_C);
  assign push       = bus.CMD_VALID && cmd_ready;
  assign fifo_empty = (count_q == '0);
  assign head_op    = mem_op_q[rd_ptr_q];
  assign head_addr  = mem_addr_q[rd_ptr_q];
  assign head_data  = mem_data_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    write_d     = 1'b0;
    read_d      = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (rsp_valid_q && bus.RSP_READY) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!head_op && bus.AMCI_WIDLE) begin
            pop     = 1'b1;
            waddr_d = head_addr;
            wdata_d = head_data;
            write_d = 1'b1;
            state_d = S_ISSUE_W;
          end else if (head_op && bus.AMCI_RIDLE && !rsp_valid_q) begin
            // read waits for the single result slot to be free
            pop     = 1'b1;
            raddr_d = head_addr;
            read_d  = 1'b1;
            state_d = S_ISSUE_R;
          end
        end
      end
      S_ISSUE_W: state_d = S_WAIT_W;
      S_WAIT_W: begin
        if (bus.AMCI_WIDLE) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE_R: state_d = S_WAIT_R;
      S_WAIT_R: begin
        if (bus.AMCI_RIDLE) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.AMCI_RDATA;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count/pointers only.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_op_q[wr_ptr_q]   <= bus.CMD_OP;
      mem_addr_q[wr_ptr_q] <= bus.CMD_ADDR;
      mem_data_q[wr_ptr_q] <= bus.CMD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      write_q     <= write_d;
      read_q      <= read_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.RSP_VALID  = rsp_valid_q;
  assign bus.RSP_DATA   = rsp_data_q;
  assign bus.AMCI_WADDR = waddr_q;
  assign bus.AMCI_WDATA = wdata_q;
  assign bus.AMCI_WRITE = write_q;
  assign bus.AMCI_RADDR = raddr_q;
  assign bus.AMCI_READ  = read_q;
  assign FIFO_COUNT     = count_q;
  assign BUSY           = (state_q != S_IDLE) || !fifo_empty;
endmodule
